// File: rtl/apb_pkg.sv
// Shared types for the APB master bridge: FSM state encoding, command/response records, default widths.
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_mst_state_e;

  typedef struct packed {
    logic                  write;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
  } apb_cmd_t;

  typedef struct packed {
    logic                  write;
    logic [APB_DATA_W-1:0] rdata;
    logic                  err;
  } apb_rsp_t;

endpackage

// File: rtl/apb_master_bridge_if.sv
// Command, response and APB bus bundle for the bridge; master = bridge side, slave = environment side.
interface apb_master_bridge_if
  import apb_pkg::*;
#(
  parameter int ADDR_W = APB_ADDR_W,
  parameter int DATA_W = APB_DATA_W
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_write;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, PRDATA, PREADY,
    output cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_err,
           PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, PRDATA, PREADY,
    input  cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_err,
           PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

endinterface

// File: rtl/apb_master_bridge.sv
// One APB transfer per command: SETUP the cycle after accept, rsp_valid 3 cycles after accept with no waits; cmd_ready only in IDLE.
// Response held until rsp_ready. Define APB_MASTER_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYC cycles with rsp_err.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_W      = APB_ADDR_W,
  parameter int DATA_W      = APB_DATA_W,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  apb_master_bridge_if.master bus
);

  apb_mst_state_e    state_q, state_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_write_q, rsp_write_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);
  logic              rsp_err_q, rsp_err_d;
  logic [15:0]       tmo_cnt_q, tmo_cnt_d;
`endif

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
`ifdef APB_MASTER_TIMEOUT_EN
    rsp_err_d   = rsp_err_q;
    tmo_cnt_d   = tmo_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          psel_d   = 1'b1;
          pwrite_d = bus.cmd_write;
          paddr_d  = bus.cmd_addr;
          pwdata_d = bus.cmd_wdata;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
        tmo_cnt_d = '0;
`endif
      end
      ACCESS: begin
        // PREADY is checked first so a ready on the limit cycle still completes normally
        if (bus.PREADY) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = pwrite_q;
          rsp_rdata_d = pwrite_q ? '0 : bus.PRDATA;
          state_d     = RESP;
`ifdef APB_MASTER_TIMEOUT_EN
          rsp_err_d   = 1'b0;
        end else if (tmo_cnt_q == TMO_LAST) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = pwrite_q;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          state_d     = RESP;
        end else begin
          tmo_cnt_d   = tmo_cnt_q + 16'd1;
`endif
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
      rsp_err_q   <= 1'b0;
      tmo_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
`ifdef APB_MASTER_TIMEOUT_EN
      rsp_err_q   <= rsp_err_d;
      tmo_cnt_q   <= tmo_cnt_d;
`endif
    end
  end

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.PSEL      = psel_q;
  assign bus.PENABLE   = penable_q;
  assign bus.PWRITE    = pwrite_q;
  assign bus.PADDR     = paddr_q;
  assign bus.PWDATA    = pwdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_write = rsp_write_q;
  assign bus.rsp_rdata = rsp_rdata_q;
`ifdef APB_MASTER_TIMEOUT_EN
  assign bus.rsp_err   = rsp_err_q;
`else
  assign bus.rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_apb_master_bridge.sv
// Scoreboard bench for apb_master_bridge: directed cases, randomized traffic, reset and (with the macro) timeout.
`timescale 1ns/1ps
module tb_apb_master_bridge;
  import apb_pkg::*;

  localparam int TMO = 8;

  logic PCLK    = 1'b0;
  logic PRESETn = 1'b0;
  always #5 PCLK = ~PCLK;

  apb_master_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  apb_master_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TMO)) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .bus     (bus.master)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: transfers complete in order, so expectations are fixed at issue time
  apb_cmd_t    cmd_q[$];
  apb_rsp_t    exp_q[$];
  int          acc_q[$];
  int          wait_q[$];
  int          hold_q[$];
  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] slv_mem[logic [31:0]];

  function automatic logic [31:0] fresh(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : fresh(a);
  endfunction

  function automatic logic [31:0] slv_read(input logic [31:0] a);
    return slv_mem.exists(a) ? slv_mem[a] : fresh(a);
  endfunction

  task automatic send(input bit w, input logic [31:0] a, input logic [31:0] d,
                      input int waits, input int hold);
    apb_cmd_t c;
    apb_rsp_t r;
    bit       tmo;
    bit       ok;
`ifdef APB_MASTER_TIMEOUT_EN
    tmo = (waits >= TMO);
`else
    tmo = 1'b0;
`endif
    c.write = w;
    c.addr  = a;
    c.wdata = d;
    r.write = w;
    r.err   = tmo;
    r.rdata = (w || tmo) ? 32'h0 : ref_read(a);
    if (w && !tmo) ref_mem[a] = d;
    cmd_q.push_back(c);
    exp_q.push_back(r);
    acc_q.push_back(tmo ? TMO : waits + 1);
    wait_q.push_back(waits);
    hold_q.push_back(hold);
    @(posedge PCLK); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge PCLK);
      if (bus.cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("cmd_accept", ok, 1);
    @(posedge PCLK); #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'($urandom);
    bus.cmd_addr  = $urandom;
    bus.cmd_wdata = $urandom;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge PCLK);
      if (exp_q.size() == 0 && bus.cmd_ready) begin
        done = 1'b1;
        break;
      end
    end
    chk("drain", done, 1);
  endtask

  // APB slave: waits per transfer come from wait_q; PREADY/PRDATA are noise outside a completing ACCESS
  initial begin
    int cur_wait;
    int sc;
    cur_wait = 0;
    sc = 0;
    bus.PREADY = 1'b0;
    bus.PRDATA = '0;
    forever begin
      @(posedge PCLK); #1;
      if (!PRESETn) begin
        bus.PREADY = 1'b0;
        sc = 0;
      end else if (bus.PSEL && !bus.PENABLE) begin
        cur_wait = (wait_q.size() != 0) ? wait_q.pop_front() : 0;
        sc = 0;
        bus.PREADY = 1'($urandom);
        bus.PRDATA = $urandom;
      end else if (bus.PSEL && bus.PENABLE) begin
        bus.PREADY = (sc == cur_wait);
        bus.PRDATA = $urandom;
        if (bus.PREADY) begin
          if (bus.PWRITE) slv_mem[bus.PADDR] = bus.PWDATA;
          else            bus.PRDATA = slv_read(bus.PADDR);
        end
        sc++;
      end else begin
        bus.PREADY = 1'($urandom);
        bus.PRDATA = $urandom;
      end
    end
  end

  // Response consumer: holds rsp_ready low for hold_q cycles of each response
  initial begin
    int vc;
    int ch;
    vc = 0;
    ch = 0;
    bus.rsp_ready = 1'b0;
    forever begin
      @(posedge PCLK); #1;
      if (!PRESETn) begin
        bus.rsp_ready = 1'b0;
        vc = 0;
      end else if (bus.rsp_valid) begin
        if (vc == 0) ch = (hold_q.size() != 0) ? hold_q.pop_front() : 0;
        bus.rsp_ready = (vc >= ch);
        vc++;
      end else begin
        vc = 0;
        bus.rsp_ready = 1'($urandom);
      end
    end
  end

  // Monitor: protocol rules and scoreboard, sampled mid-cycle
  bit          prev_psel = 0, prev_pen = 0, prev_rv = 0, prev_rr = 0;
  int          acc_cnt   = 0;
  int          acc_edge  = -1;
  apb_cmd_t    cur;
  logic [33:0] last_rsp;

  always @(negedge PCLK) begin
    apb_rsp_t r;
    int       a;
    if (!PRESETn) begin
      chk("rst_psel", bus.PSEL, 0);
      chk("rst_penable", bus.PENABLE, 0);
      prev_psel = 0; prev_pen = 0; prev_rv = 0; prev_rr = 0;
      acc_cnt = 0;
    end else begin
      chk("cmd_ready_idle_only", bus.cmd_ready, !(bus.PSEL || bus.rsp_valid));
      if (bus.PENABLE) chk("penable_implies_psel", bus.PSEL, 1);
      if (bus.PSEL && !bus.PENABLE) begin
        chk("idle_gap_before_setup", prev_psel, 0);
        chk("setup_latency", cyc, acc_edge);
        if (cmd_q.size() == 0) begin
          chk("unexpected_setup", cmd_q.size(), 1);
        end else begin
          cur = cmd_q.pop_front();
          chk("paddr", bus.PADDR, cur.addr);
          chk("pwrite", bus.PWRITE, cur.write);
          if (cur.write) chk("pwdata", bus.PWDATA, cur.wdata);
        end
        acc_cnt = 0;
      end
      if (bus.PSEL && bus.PENABLE) begin
        chk("access_follows_setup", prev_psel, 1);
        chk("paddr_stable", bus.PADDR, cur.addr);
        chk("pwrite_stable", bus.PWRITE, cur.write);
        if (cur.write) chk("pwdata_stable", bus.PWDATA, cur.wdata);
        acc_cnt++;
      end
      if (bus.rsp_valid) begin
        chk("bus_idle_in_resp", {bus.PSEL, bus.PENABLE}, 0);
        if (!prev_rv) begin
          chk("rsp_after_access", prev_pen, 1);
          if (exp_q.size() == 0) begin
            chk("unexpected_rsp", exp_q.size(), 1);
          end else begin
            r = exp_q.pop_front();
            a = acc_q.pop_front();
            chk("rsp_write", bus.rsp_write, r.write);
            chk("rsp_rdata", bus.rsp_rdata, r.rdata);
            chk("rsp_err", bus.rsp_err, r.err);
            chk("access_cycles", acc_cnt, a);
          end
        end else if (!prev_rr) begin
          chk("rsp_stable", {bus.rsp_write, bus.rsp_rdata, bus.rsp_err}, last_rsp);
        end
        last_rsp = {bus.rsp_write, bus.rsp_rdata, bus.rsp_err};
      end
      if (prev_rv && prev_rr) begin
        chk("rsp_drop_after_hs", bus.rsp_valid, 0);
        chk("cmd_ready_after_hs", bus.cmd_ready, 1);
      end
      if (bus.cmd_valid && bus.cmd_ready) acc_edge = cyc + 1;
      prev_psel = bus.PSEL;
      prev_pen  = bus.PENABLE;
      prev_rv   = bus.rsp_valid;
      prev_rr   = bus.rsp_ready;
    end
  end

  initial begin
    #500000;
    bad++;
    $display("FAIL watchdog: got still running want finished (cycle %0d)", cyc);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit seen;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;

    repeat (3) @(negedge PCLK);
    chk("reset_psel", bus.PSEL, 0);
    chk("reset_penable", bus.PENABLE, 0);
    chk("reset_pwrite", bus.PWRITE, 0);
    chk("reset_paddr", bus.PADDR, 0);
    chk("reset_pwdata", bus.PWDATA, 0);
    chk("reset_rsp_valid", bus.rsp_valid, 0);
    chk("reset_rsp_write", bus.rsp_write, 0);
    chk("reset_rsp_rdata", bus.rsp_rdata, 0);
    chk("reset_rsp_err", bus.rsp_err, 0);
    chk("reset_cmd_ready", bus.cmd_ready, 1);
    @(posedge PCLK); #1;
    PRESETn = 1'b1;

    // Single write, zero waits
    send(1'b1, 32'h10, 32'hDEADBEEF, 0, 0);
    drain();

    // Read with three wait states
    slv_mem[32'h10] = 32'hCAFEF00D;
    ref_mem[32'h10] = 32'hCAFEF00D;
    send(1'b0, 32'h10, 32'h0, 3, 0);
    drain();

    // Response backpressure, with a second command waiting behind it
    send(1'b0, 32'h10, 32'h0, 0, 5);
    send(1'b1, 32'h14, 32'h0BAD_CAFE, 2, 5);
    drain();

    // Back-to-back write then read of the same address
    send(1'b1, 32'h20, 32'h600DF00D, 0, 0);
    send(1'b0, 32'h20, 32'h0, 0, 0);
    drain();

`ifdef APB_MASTER_TIMEOUT_EN
    send(1'b1, 32'h30, 32'h12345678, 1000, 0);
    send(1'b0, 32'h30, 32'h0, TMO - 1, 0);
    send(1'b0, 32'h10, 32'h0, 1000, 2);
    drain();
`endif

    for (int n = 0; n < 60; n++) begin
      int wmax;
`ifdef APB_MASTER_TIMEOUT_EN
      wmax = 10;
`else
      wmax = 4;
`endif
      send(1'($urandom), 32'h100 + (32'($urandom_range(0, 7)) << 2), $urandom,
           $urandom_range(0, wmax), $urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(0, 3)) @(posedge PCLK);
    end
    drain();

    // Reset in the middle of ACCESS
    send(1'b0, 32'h40, 32'h0, 6, 0);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge PCLK);
      if (bus.PSEL && bus.PENABLE) begin
        seen = 1'b1;
        break;
      end
    end
    chk("reached_access", seen, 1);
    @(negedge PCLK); #2;
    PRESETn = 1'b0;
    #1;
    chk("midreset_psel", bus.PSEL, 0);
    chk("midreset_penable", bus.PENABLE, 0);
    chk("midreset_rsp_valid", bus.rsp_valid, 0);
    cmd_q.delete();
    exp_q.delete();
    acc_q.delete();
    wait_q.delete();
    hold_q.delete();
    repeat (2) @(posedge PCLK);
    #1;
    PRESETn = 1'b1;
    @(negedge PCLK);
    chk("post_reset_cmd_ready", bus.cmd_ready, 1);
    for (int i = 0; i < 15; i++) begin
      @(negedge PCLK);
      chk("post_reset_no_rsp", bus.rsp_valid, 0);
    end

    send(1'b0, 32'h20, 32'h0, 1, 1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
